coprocessor: RTL and testbench
==============================

COPROCESSOR -- requirements
Module: coprocessor

Interface
REQ-001 The interface SHALL have one clock and a synchronous, active-high reset; ports SHALL be exactly as listed in REQ-002 to REQ-009.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 start  input  1  level request; a rising edge, sampled on clk, launches the operation.
REQ-005 op_code  input  3  operation select, sampled at launch.
REQ-006 matrix_a  input  200  5x5 signed 8-bit matrix A, sampled at launch.
REQ-007 matrix_b  input  200  5x5 signed 8-bit matrix B, sampled at launch.
REQ-008 scalar  input  8  signed scalar, sampled at launch.
REQ-009 result_final  output  200  registered 5x5 signed 8-bit result; overflow  output  1  registered, set if any true result is outside -128..127.

Function
REQ-010 Packing: element i = 5*row + col occupies bits [8i+7:8i], two's complement; same packing for all matrix ports.
REQ-011 Launch: a clock edge with start=1, previous sampled start=0 and FSM in IDLE; start held high SHALL NOT relaunch; launches while BUSY SHALL be ignored.
REQ-012 op_code map: 000 A+B; 001 A-B; 010 A*B (matrix product); 011 scalar*A; 100 transpose(A); 101 -A; 110 determinant(A); 111 reserved.
REQ-013 For 111, result_final SHALL be 0 and overflow SHALL be 0.
REQ-014 Ops 000-101 and 111 SHALL update result_final and overflow on the launch edge itself (visible one cycle after start rises).
REQ-015 Element arithmetic: full-precision signed (product sums at least 18 bits); stored element = low 8 bits of the true value (wrap, no saturation).
REQ-016 overflow SHALL be the OR over all 25 elements of (true value outside -128..127); transpose never overflows; -(-128) overflows.
REQ-017 Determinant: the FSM SHALL go IDLE->BUSY on launch, compute det(A) exactly by fraction-free (Bareiss) elimination with row swap on zero pivot (sign flip), then go BUSY->IDLE, within 48 cycles of launch.
REQ-018 Determinant result: element 0 = low 8 bits of det; elements 1-24 = 0; overflow = det outside -128..127; both written once, on completion.
REQ-019 Singular A, including an all-zero pivot column, SHALL yield det=0 and overflow=0.
REQ-020 Between operations result_final and overflow SHALL hold their last values; input changes after launch SHALL NOT affect the operation in progress.

Reset
REQ-021 When rst=1 at a clock edge: result_final=0, overflow=0, FSM=IDLE, and the previous-start register=0.
REQ-022 rst SHALL take priority over a launch in the same cycle and SHALL abort a determinant in progress, discarding it.
REQ-023 After rst deasserts, a start already high SHALL NOT launch until it has been seen low.

Configuration
REQ-024 Macro COPROC_DET_EN: when defined, op 110 SHALL behave per REQ-017 to REQ-019.
REQ-025 When COPROC_DET_EN is not defined: op 110 SHALL behave like 111 (one-cycle result 0, overflow 0); no BUSY state or elimination datapath SHALL be built.

Verification
REQ-026 A elements = 1..25, B elements all 1, op 001, start rising -> after one cycle element i = i (element 0 = 0, element 24 = 24), overflow=0.
REQ-027 Same A and B, op 010 -> row sums in every column: rows 0-4 = 15, 40, 65, 90, 115; overflow=0; op 000 -> element i = i+2.
REQ-028 A elements = 1..25: op 011 with scalar=3 -> element 24 = 75, overflow=0; scalar=6 -> element 24 = -106, overflow=1; op 100 -> element 1 = 6, element 5 = 2.
REQ-029 With COPROC_DET_EN: A = 2*identity, op 110 -> within 48 cycles element 0 = 32, overflow=0; A = 1..25 -> 0; A = 3*identity -> element 0 = -13 (243 wrapped), overflow=1.
REQ-030 rst pulsed mid-determinant -> next edge result_final=0, overflow=0; start held high since before reset gives no launch; a new low->high start launches normally.

Source files
------------

// File: rtl/coprocessor.sv
// 5x5 signed 8-bit matrix coprocessor.
// Element-wise ops, matrix product, scalar multiply, transpose and negate
// complete on the launch edge. Determinant (op 110) is built only when the
// macro COPROC_DET_EN is defined; otherwise op 110 returns zero like op 111.
module coprocessor (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op_code,
  input  logic [199:0] matrix_a,
  input  logic [199:0] matrix_b,
  input  logic [7:0]   scalar,
  output logic [199:0] result_final,
  output logic         overflow
);

`ifdef COPROC_DET_EN
  typedef enum logic [0:0] {IDLE, BUSY} state_t;
`else
  typedef enum logic [0:0] {IDLE} state_t;
`endif

  state_t state;
  logic   start_q;
  logic   armed;
  logic   launch;

  logic signed [7:0]  a_e [25];
  logic signed [7:0]  b_e [25];
  logic [199:0]       quick_res;
  logic               quick_ovf;

  function automatic logic signed [19:0] sx8(input logic [7:0] x);
    return $signed({{12{x[7]}}, x});
  endfunction

  // Unpack the operand ports into element arrays.
  always_comb begin
    for (int unsigned i = 0; i < 25; i++) begin
      a_e[i] = matrix_a[8*i +: 8];
      b_e[i] = matrix_b[8*i +: 8];
    end
  end

  // A rising edge is only honoured once start has been seen low since reset.
  assign launch = start && !start_q && armed && (state == IDLE);

  // Full-precision result of the single-cycle ops, wrapped to 8 bits per element.
  always_comb begin
    logic signed [19:0] v;
    int unsigned r;
    int unsigned c;
    quick_res = '0;
    quick_ovf = 1'b0;
    for (int unsigned i = 0; i < 25; i++) begin
      r = i / 5;
      c = i % 5;
      v = '0;
      case (op_code)
        3'b000: v = sx8(a_e[i]) + sx8(b_e[i]);
        3'b001: v = sx8(a_e[i]) - sx8(b_e[i]);
        3'b010: begin
          for (int unsigned k = 0; k < 5; k++)
            v = v + sx8(a_e[r*5+k]) * sx8(b_e[k*5+c]);
        end
        3'b011: v = sx8(a_e[i]) * sx8(scalar);
        3'b100: v = sx8(a_e[c*5+r]);
        3'b101: v = -sx8(a_e[i]);
        default: v = '0;
      endcase
      quick_res[8*i +: 8] = v[7:0];
      if (v > 127 || v < -128) quick_ovf = 1'b1;
    end
  end

`ifdef COPROC_DET_EN
  // Bareiss working matrix; every entry is a minor of A, so 48 bits is ample.
  logic signed [47:0] m     [5][5];
  logic signed [47:0] sw    [5][5];
  logic signed [47:0] m_nxt [5][5];
  logic signed [47:0] prev;
  logic signed [47:0] det_val;
  logic [2:0]         k;
  logic               neg;
  logic               found;
  logic               swapped;
  logic [2:0]         p;

  function automatic logic signed [95:0] sx48(input logic [47:0] x);
    return $signed({{48{x[47]}}, x});
  endfunction

  // One elimination step: pick the first nonzero pivot at or below row k,
  // swap it into place, then apply the fraction-free update to the trailing block.
  always_comb begin
    logic signed [95:0] t;
    logic signed [95:0] q;
    found = 1'b0;
    p     = k;
    for (int unsigned r = 0; r < 5; r++) begin
      if (!found && r >= 32'(k) && m[r][k] != 0) begin
        found = 1'b1;
        p     = 3'(r);
      end
    end
    swapped = found && (p != k);
    sw = m;
    if (found) begin
      sw[k] = m[p];
      sw[p] = m[k];
    end
    m_nxt = sw;
    for (int unsigned i = 0; i < 5; i++) begin
      for (int unsigned j = 0; j < 5; j++) begin
        t = '0;
        q = '0;
        if (i > 32'(k) && j > 32'(k)) begin
          t = sx48(sw[i][j]) * sx48(sw[k][k]) - sx48(sw[i][k]) * sx48(sw[k][j]);
          q = t / sx48(prev);
          m_nxt[i][j] = q[47:0];
        end
      end
    end
    det_val = (neg ^ swapped) ? -m_nxt[4][4] : m_nxt[4][4];
  end
`endif

  // Control FSM, launch detection and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      armed        <= 1'b0;
      result_final <= '0;
      overflow     <= 1'b0;
`ifdef COPROC_DET_EN
      k            <= '0;
      neg          <= 1'b0;
      prev         <= 48'sd1;
`endif
    end else begin
      start_q <= start;
      if (!start) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (launch) begin
`ifdef COPROC_DET_EN
            if (op_code == 3'b110) begin
              for (int unsigned i = 0; i < 5; i++)
                for (int unsigned j = 0; j < 5; j++)
                  m[i][j] <= {{40{a_e[5*i+j][7]}}, a_e[5*i+j]};
              prev  <= 48'sd1;
              k     <= '0;
              neg   <= 1'b0;
              state <= BUSY;
            end else begin
              result_final <= quick_res;
              overflow     <= quick_ovf;
            end
`else
            result_final <= quick_res;
            overflow     <= quick_ovf;
`endif
          end
        end
`ifdef COPROC_DET_EN
        BUSY: begin
          if (!found) begin
            result_final <= '0;
            overflow     <= 1'b0;
            state        <= IDLE;
          end else begin
            m    <= m_nxt;
            prev <= sw[k][k];
            neg  <= neg ^ swapped;
            k    <= k + 3'd1;
            if (k == 3'd3) begin
              result_final <= {192'b0, det_val[7:0]};
              overflow     <= (det_val > 127) || (det_val < -128);
              state        <= IDLE;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coprocessor.sv
// Randomized self-checking bench for coprocessor with a cofactor-expansion
// reference model. Determinant expectations follow COPROC_DET_EN.
module tb_coprocessor;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op_code;
  logic [199:0] matrix_a;
  logic [199:0] matrix_b;
  logic [7:0]   scalar;
  logic [199:0] result_final;
  logic         overflow;

  int checks = 0;
  int errors = 0;

`ifdef COPROC_DET_EN
  localparam bit DET_EN = 1'b1;
`else
  localparam bit DET_EN = 1'b0;
`endif

  coprocessor dut (
    .clk(clk), .rst(rst), .start(start), .op_code(op_code),
    .matrix_a(matrix_a), .matrix_b(matrix_b), .scalar(scalar),
    .result_final(result_final), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [199:0] pack(input int m[25]);
    logic [199:0] p;
    int t;
    p = '0;
    for (int i = 0; i < 25; i++) begin
      t = m[i];
      p[8*i +: 8] = t[7:0];
    end
    return p;
  endfunction

  function automatic longint det3(input longint m[3][3]);
    return m[0][0]*(m[1][1]*m[2][2] - m[1][2]*m[2][1])
         - m[0][1]*(m[1][0]*m[2][2] - m[1][2]*m[2][0])
         + m[0][2]*(m[1][0]*m[2][1] - m[1][1]*m[2][0]);
  endfunction

  function automatic longint det4(input longint m[4][4]);
    longint s;
    longint mn[3][3];
    int cc;
    s = 0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 1; r < 4; r++) begin
        cc = 0;
        for (int j = 0; j < 4; j++)
          if (j != c) begin mn[r-1][cc] = m[r][j]; cc++; end
      end
      if (c % 2 == 0) s += m[0][c] * det3(mn);
      else            s -= m[0][c] * det3(mn);
    end
    return s;
  endfunction

  function automatic longint det5(input int a[25]);
    longint s;
    longint mn[4][4];
    int cc;
    s = 0;
    for (int c = 0; c < 5; c++) begin
      for (int r = 1; r < 5; r++) begin
        cc = 0;
        for (int j = 0; j < 5; j++)
          if (j != c) begin mn[r-1][cc] = longint'(a[r*5+j]); cc++; end
      end
      if (c % 2 == 0) s += longint'(a[c]) * det4(mn);
      else            s -= longint'(a[c]) * det4(mn);
    end
    return s;
  endfunction

  function automatic void model(input int op, input int a[25], input int b[25], input int s,
                                output logic [199:0] res, output logic ovf);
    int v;
    longint d;
    res = '0;
    ovf = 1'b0;
    if (op == 6) begin
      if (DET_EN) begin
        d = det5(a);
        res[7:0] = d[7:0];
        ovf = (d > 127) || (d < -128);
      end
    end else begin
      for (int i = 0; i < 25; i++) begin
        case (op)
          0: v = a[i] + b[i];
          1: v = a[i] - b[i];
          2: begin
            v = 0;
            for (int k = 0; k < 5; k++) v += a[(i/5)*5+k] * b[k*5+(i%5)];
          end
          3: v = a[i] * s;
          4: v = a[(i%5)*5 + i/5];
          5: v = -a[i];
          default: v = 0;
        endcase
        res[8*i +: 8] = v[7:0];
        if (v > 127 || v < -128) ovf = 1'b1;
      end
    end
  endfunction

  task automatic scramble();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[32*i +: 32] = $urandom;
    matrix_a = t[199:0];
    for (int i = 0; i < 7; i++) t[32*i +: 32] = $urandom;
    matrix_b = t[199:0];
    scalar = 8'($urandom);
  endtask

  // Launch one operation from a clean low->high start, then disturb the
  // inputs and confirm the registered result is unaffected.
  task automatic run_op(input int op, input int a[25], input int b[25], input int s, input string tag);
    logic [199:0] er;
    logic         eo;
    logic [2:0]   opv;
    logic [7:0]   sv;
    opv = 3'(op);
    sv  = 8'(s);
    model(op, a, b, s, er, eo);
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    op_code = opv; matrix_a = pack(a); matrix_b = pack(b); scalar = sv; start = 1'b1;
    if (op == 6 && DET_EN) begin
      @(negedge clk);
      scramble(); op_code = 3'b000; start = 1'b0;
      @(negedge clk) start = 1'b1;
      repeat (46) @(negedge clk);
      check({tag, "_res"}, result_final, er);
      check({tag, "_ovf"}, {199'b0, overflow}, {199'b0, eo});
    end else begin
      @(negedge clk);
      check({tag, "_res"}, result_final, er);
      check({tag, "_ovf"}, {199'b0, overflow}, {199'b0, eo});
      scramble(); op_code = 3'($urandom);
      repeat (2) @(negedge clk);
      check({tag, "_hold"}, result_final, er);
    end
  endtask

  int seq [25];
  int ones[25];
  int id2 [25];
  int id3 [25];
  int m128[25];
  int zc  [25];
  int ra  [25];
  int rb  [25];
  logic [199:0] er;
  logic         eo;

  initial begin
    rst = 1'b1; start = 1'b0; op_code = '0; matrix_a = '0; matrix_b = '0; scalar = '0;
    for (int i = 0; i < 25; i++) begin
      seq[i]  = i + 1;
      ones[i] = 1;
      id2[i]  = (i % 6 == 0) ? 2 : 0;
      id3[i]  = (i % 6 == 0) ? 3 : 0;
      m128[i] = -128;
      zc[i]   = (i % 5 == 0) ? 0 : int'($urandom_range(9)) - 4;
    end
    repeat (3) @(negedge clk);
    check("reset_res", result_final, '0);
    check("reset_ovf", {199'b0, overflow}, '0);
    rst = 1'b0;

    run_op(1, seq, ones, 0, "sub");
    run_op(2, seq, ones, 0, "mul");
    run_op(0, seq, ones, 0, "add");
    run_op(3, seq, ones, 3, "scal3");
    check("scal3_e24", {192'b0, result_final[199:192]}, 200'd75);
    run_op(3, seq, ones, 6, "scal6");
    check("scal6_e24", {192'b0, result_final[199:192]}, {192'b0, 8'h96});
    check("scal6_ovf1", {199'b0, overflow}, 200'd1);
    run_op(4, seq, ones, 0, "trans");
    check("trans_e1", {192'b0, result_final[15:8]}, 200'd6);
    run_op(5, seq, ones, 0, "neg");
    run_op(5, m128, ones, 0, "neg128");
    run_op(7, seq, ones, 5, "rsvd");
    run_op(6, id2, ones, 0, "det2i");
    run_op(6, seq, ones, 0, "detseq");
    run_op(6, id3, ones, 0, "det3i");
    run_op(6, zc, ones, 0, "detzc");

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 25; i++) begin
        ra[i] = int'($urandom_range(255)) - 128;
        rb[i] = int'($urandom_range(255)) - 128;
      end
      if (n % 3 == 0)
        for (int i = 0; i < 25; i++) ra[i] = int'($urandom_range(6)) - 3;
      run_op(int'($urandom_range(7)), ra, rb, int'($urandom_range(255)) - 128, $sformatf("rnd%0d", n));
    end

    // Reset in the middle of a determinant, with start held high throughout.
    run_op(0, seq, ones, 0, "pre_rst");
    @(negedge clk) start = 1'b0;
    @(negedge clk) begin op_code = 3'b110; matrix_a = pack(id2); start = 1'b1; end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("rst_abort_res", result_final, '0);
    check("rst_abort_ovf", {199'b0, overflow}, '0);
    op_code = 3'b000; matrix_a = pack(seq); matrix_b = pack(ones); rst = 1'b0;
    repeat (50) @(negedge clk);
    check("rst_nolaunch", result_final, '0);
    start = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    model(0, seq, ones, 0, er, eo);
    check("rst_relaunch", result_final, er);

    // Reset wins over a launch in the same cycle; start still high afterwards.
    @(negedge clk) start = 1'b0;
    @(negedge clk) begin op_code = 3'b001; start = 1'b1; rst = 1'b1; end
    @(negedge clk);
    check("rst_prio", result_final, '0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_prio_hold", result_final, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
